// File: rtl/bcd_stopwatch_ctrl_if.sv
// Signal bundle between the stopwatch controller and the buttons, target and
// 3-digit BCD counter it sequences.
interface bcd_stopwatch_ctrl_if;
    logic        BtnStartStop;
    logic        BtnLap;
    logic        BtnClear;
    logic [11:0] Target;
    logic [3:0]  Co1;
    logic [3:0]  Co10;
    logic [3:0]  Co100;
    logic        CntEnable;
    logic        CntnReset;
    logic [3:0]  Disp1;
    logic [3:0]  Disp10;
    logic [3:0]  Disp100;
    logic        Running;
    logic        Done;

    modport master (
        output BtnStartStop, BtnLap, BtnClear, Target, Co1, Co10, Co100,
        input  CntEnable, CntnReset, Disp1, Disp10, Disp100, Running, Done
    );

    modport slave (
        input  BtnStartStop, BtnLap, BtnClear, Target, Co1, Co10, Co100,
        output CntEnable, CntnReset, Disp1, Disp10, Disp100, Running, Done
    );
endinterface

// File: rtl/bcd_stopwatch_ctrl.sv
// Stopwatch sequencer for a cascaded 3-digit BCD counter: prescaled count
// enable, start/stop, lap freeze, clear and stop-at-target.
module bcd_stopwatch_ctrl #(
    parameter int PRESCALE = 4,
    parameter int PW       = 16
) (
    input  logic               Clock,
    input  logic               nReset,
    bcd_stopwatch_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        LAP,
        PAUSE,
        DONE
    } state_t;

    state_t      state, state_n;
    logic [PW-1:0] presc, presc_n;
    logic [11:0] lap_q, lap_n;
    logic        tick_n;
    logic        cnt_en, cnt_nrst;
    logic        running, done;
    logic        prev_ss, prev_lap, prev_clr;
    logic        ev_clr, ev_ss, ev_lap;
    logic [11:0] count;
    logic        target_ok, match, wrap;

    assign count = {bus.Co100, bus.Co10, bus.Co1};

    // Clear outranks StartStop, which outranks Lap; losers are dropped
    assign ev_clr = bus.BtnClear & ~prev_clr;
    assign ev_ss  = bus.BtnStartStop & ~prev_ss & ~ev_clr;
    assign ev_lap = bus.BtnLap & ~prev_lap & ~ev_clr & ~ev_ss;

    assign target_ok = (bus.Target != 12'h000) && (bus.Target[3:0] <= 4'd9) &&
                       (bus.Target[7:4] <= 4'd9) && (bus.Target[11:8] <= 4'd9);
    assign match = target_ok && (count == bus.Target) && (state == RUN || state == LAP);
    assign wrap  = (presc == PW'(PRESCALE - 1));

    always_comb begin
        state_n = state;
        presc_n = presc;
        lap_n   = lap_q;
        tick_n  = 1'b0;
        case (state)
            IDLE: begin
                presc_n = '0;
                if (ev_ss) state_n = RUN;
            end
            RUN, LAP: begin
                if (match) begin
                    state_n = DONE;
                    presc_n = '0;
                end else begin
                    if (wrap) begin
                        presc_n = '0;
                        tick_n  = 1'b1;
                    end else begin
                        presc_n = presc + 1'b1;
                    end
                    if (ev_ss) begin
                        state_n = PAUSE;
                    end else if (ev_lap) begin
                        if (state == RUN) begin
                            state_n = LAP;
                            lap_n   = count;
                        end else begin
                            state_n = RUN;
                        end
                    end
                end
            end
            PAUSE: begin
                if (ev_ss) state_n = RUN;
            end
            DONE: begin
                presc_n = '0;
            end
            default: begin
                state_n = IDLE;
                presc_n = '0;
            end
        endcase
        if (ev_clr) begin
            state_n = IDLE;
            presc_n = '0;
            lap_n   = '0;
            tick_n  = 1'b0;
        end
    end

    always_ff @(posedge Clock) begin
        if (!nReset) begin
            state    <= IDLE;
            presc    <= '0;
            lap_q    <= '0;
            cnt_en   <= 1'b0;
            cnt_nrst <= 1'b0;
            running  <= 1'b0;
            done     <= 1'b0;
            prev_ss  <= 1'b0;
            prev_lap <= 1'b0;
            prev_clr <= 1'b0;
        end else begin
            state    <= state_n;
            presc    <= presc_n;
            lap_q    <= lap_n;
            cnt_en   <= tick_n;
            cnt_nrst <= ~ev_clr;
            running  <= (state_n == RUN) || (state_n == LAP);
            done     <= (state_n == DONE);
            prev_ss  <= bus.BtnStartStop;
            prev_lap <= bus.BtnLap;
            prev_clr <= bus.BtnClear;
        end
    end

    assign bus.CntEnable = cnt_en;
    assign bus.CntnReset = cnt_nrst;
    assign bus.Running   = running;
    assign bus.Done      = done;
    assign {bus.Disp100, bus.Disp10, bus.Disp1} = (state == LAP) ? lap_q : count;

endmodule

// File: tb/tb_bcd_stopwatch_ctrl.sv
// Bench for bcd_stopwatch_ctrl: behavioural BCD counter on the outputs plus a
// queue of expected CntEnable cycles checked as ticks appear.
module tb_bcd_stopwatch_ctrl;

    localparam int P = 4;

    logic Clock = 1'b0;
    logic nReset;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    int   exp_q[$];
    logic [11:0] cnt = '0;
    int   n, r, c;

    bcd_stopwatch_ctrl_if bus();

    bcd_stopwatch_ctrl #(.PRESCALE(P), .PW(16)) dut (
        .Clock (Clock),
        .nReset(nReset),
        .bus   (bus)
    );

    always #5 Clock = ~Clock;
    always @(posedge Clock) cyc <= cyc + 1;

    function automatic logic [11:0] bcd_inc(input logic [11:0] v);
        logic [3:0] d0, d1, d2;
        {d2, d1, d0} = v;
        if (d0 == 4'd9) begin
            d0 = 4'd0;
            if (d1 == 4'd9) begin
                d1 = 4'd0;
                d2 = (d2 == 4'd9) ? 4'd0 : d2 + 4'd1;
            end else begin
                d1 = d1 + 4'd1;
            end
        end else begin
            d0 = d0 + 4'd1;
        end
        return {d2, d1, d0};
    endfunction

    // External counter the controller drives
    always @(posedge Clock) begin
        if (!bus.CntnReset) cnt <= '0;
        else if (bus.CntEnable) cnt <= bcd_inc(cnt);
    end
    assign bus.Co1   = cnt[3:0];
    assign bus.Co10  = cnt[7:4];
    assign bus.Co100 = cnt[11:8];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(negedge Clock) begin
        if (bus.CntEnable === 1'b1) begin
            if (exp_q.size() == 0) check_eq("tick_extra", bus.CntEnable, 0);
            else check_eq("tick_cycle", cyc, exp_q.pop_front());
        end
    end

    task automatic push_ticks(input int first, input int num);
        for (int i = 0; i < num; i++) exp_q.push_back(first + P * i);
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge Clock);
    endtask

    task automatic press(input bit ss, input bit lap, input bit clr, output int ev);
        ev = cyc + 1;
        bus.BtnStartStop = ss;
        bus.BtnLap       = lap;
        bus.BtnClear     = clr;
        @(negedge Clock);
        bus.BtnStartStop = 1'b0;
        bus.BtnLap       = 1'b0;
        bus.BtnClear     = 1'b0;
    endtask

    function automatic logic [11:0] disp();
        return {bus.Disp100, bus.Disp10, bus.Disp1};
    endfunction

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        nReset = 1'b0;
        bus.BtnStartStop = 1'b0;
        bus.BtnLap = 1'b0;
        bus.BtnClear = 1'b0;
        bus.Target = 12'h000;
        repeat (3) @(negedge Clock);
        check_eq("rst_cntnreset", bus.CntnReset, 0);
        check_eq("rst_cntenable", bus.CntEnable, 0);
        check_eq("rst_running", bus.Running, 0);
        check_eq("rst_done", bus.Done, 0);
        nReset = 1'b1;
        @(negedge Clock);
        check_eq("rel_cntnreset", bus.CntnReset, 1);
        check_eq("rel_disp", disp(), 12'h000);

        // Start, count, pause at 012, resume, lap at 034
        press(1, 0, 0, n);
        push_ticks(n + P, 12);
        check_eq("run_running", bus.Running, 1);
        wait_until(n + 21);
        check_eq("run_disp5", disp(), 12'h005);
        wait_until(n + 49);
        check_eq("run_disp12", disp(), 12'h012);
        press(1, 0, 0, c);
        repeat (50) @(negedge Clock);
        check_eq("pause_disp", disp(), 12'h012);
        check_eq("pause_running", bus.Running, 0);
        press(1, 0, 0, r);
        push_ticks(r + 2, 29);
        check_eq("resume_running", bus.Running, 1);
        wait_until(r + 88);
        press(0, 1, 0, c);
        wait_until(r + 112);
        check_eq("lap_disp_frozen", disp(), 12'h034);
        check_eq("lap_running", bus.Running, 1);
        press(0, 1, 0, c);
        check_eq("lap_disp_live", disp(), 12'h040);
        check_eq("lap2_running", bus.Running, 1);
        wait_until(r + 115);
        press(0, 0, 1, c);
        check_eq("clr_cntnreset_lo", bus.CntnReset, 0);
        check_eq("clr_running", bus.Running, 0);
        @(negedge Clock);
        check_eq("clr_cntnreset_hi", bus.CntnReset, 1);
        check_eq("clr_disp", disp(), 12'h000);
        check_eq("s1_ticks_left", exp_q.size(), 0);

        // Stop at target 025
        bus.Target = 12'h025;
        press(1, 0, 0, n);
        push_ticks(n + P, 25);
        wait_until(n + 103);
        check_eq("tgt_done", bus.Done, 1);
        check_eq("tgt_running", bus.Running, 0);
        check_eq("tgt_disp", disp(), 12'h025);
        repeat (100) @(negedge Clock);
        press(1, 0, 0, c);
        @(negedge Clock);
        check_eq("tgt_ss_ignored", bus.Done, 1);
        check_eq("tgt_disp_hold", disp(), 12'h025);
        press(0, 0, 1, c);
        check_eq("tgt_clr_lo", bus.CntnReset, 0);
        check_eq("tgt_clr_done", bus.Done, 0);
        @(negedge Clock);
        check_eq("tgt_clr_hi", bus.CntnReset, 1);
        check_eq("tgt_clr_disp", disp(), 12'h000);
        check_eq("tgt_ticks_left", exp_q.size(), 0);
        bus.Target = 12'h000;

        // Free-run through 999 -> 000
        press(1, 0, 0, n);
        push_ticks(n + P, 1003);
        wait_until(n + 4002);
        check_eq("wrap_disp0", disp(), 12'h000);
        check_eq("wrap_done0", bus.Done, 0);
        wait_until(n + 4014);
        check_eq("wrap_disp3", disp(), 12'h003);
        check_eq("wrap_done3", bus.Done, 0);
        check_eq("wrap_running", bus.Running, 1);
        press(0, 0, 1, c);
        @(negedge Clock);
        check_eq("wrap_ticks_left", exp_q.size(), 0);

        // Clear and StartStop together in RUN
        press(1, 0, 0, n);
        push_ticks(n + P, 2);
        wait_until(n + 9);
        press(1, 0, 1, c);
        check_eq("both_running", bus.Running, 0);
        check_eq("both_cntnreset", bus.CntnReset, 0);
        repeat (5) @(negedge Clock);
        check_eq("both_disp", disp(), 12'h000);
        check_eq("both_ticks_left", exp_q.size(), 0);
        press(1, 0, 0, n);
        push_ticks(n + P, 2);
        check_eq("both_restart", bus.Running, 1);

        // Reset mid-run
        wait_until(n + 9);
        nReset = 1'b0;
        @(negedge Clock);
        check_eq("mid_rst_cntnreset", bus.CntnReset, 0);
        check_eq("mid_rst_cntenable", bus.CntEnable, 0);
        check_eq("mid_rst_running", bus.Running, 0);
        check_eq("mid_rst_done", bus.Done, 0);
        nReset = 1'b1;
        @(negedge Clock);
        check_eq("mid_rel_cntnreset", bus.CntnReset, 1);
        check_eq("mid_rel_disp", disp(), 12'h000);
        repeat (10) @(negedge Clock);
        check_eq("mid_ticks_left", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/bcd_stopwatch_ctrl.md
Name: bcd_stopwatch_ctrl

Overview:
- Controller for the 3-digit cascaded BCD counter (000–999) used in the lab designs.
- Generates the counter's Enable tick from a clock prescaler and issues a synchronous counter clear.
- Sequences Start/Stop, Lap (frozen display) and Clear button events.
- Stops counting and flags Done when the counter reaches a programmable BCD target.

Parameters:
- PRESCALE, 4, Clock cycles per count tick; legal range 2..65535.
- PW, 16, prescaler register width; must satisfy 2^PW >= PRESCALE.

Ports:
- Clock  in  1  system clock, all logic on rising edge
- nReset  in  1  synchronous, active-low reset
- BtnStartStop  in  1  start/stop request, level input (already synchronized); acts on rising edge
- BtnLap  in  1  lap request; acts on rising edge
- BtnClear  in  1  clear request; acts on rising edge
- Target  in  12  BCD target {hundreds,tens,ones}; 12'h000 = no target (free-run)
- Co1  in  4  counter ones digit
- Co10  in  4  counter tens digit
- Co100  in  4  counter hundreds digit
- CntEnable  out  1  one-cycle tick to the counter Enable
- CntnReset  out  1  active-low synchronous clear to the counter nReset
- Disp1  out  4  displayed ones digit
- Disp10  out  4  displayed tens digit
- Disp100  out  4  displayed hundreds digit
- Running  out  1  high in RUN or LAP
- Done  out  1  high in DONE

Behaviour:
- Reset (nReset=0 at edge):
  - state=IDLE, prescaler=0, CntEnable=0, CntnReset=0 (holds counter clear), lap register=000, Done=0, Running=0.
  - Button edge detectors clear their previous-value registers to 0.
- CntnReset returns to 1 on the first edge with nReset=1.
- Edge detect: event = input high now and low on the previous cycle; one event per press.
- Event priority within a cycle: Clear > StartStop > Lap; lower-priority events in the same cycle are dropped.
- States and transitions:
  - IDLE: StartStop -> RUN, prescaler=0.
  - RUN:
    - StartStop -> PAUSE.
    - Lap -> LAP; lap register loaded with {Co100,Co10,Co1} from that cycle.
    - Target match -> DONE.
  - LAP:
    - Lap -> RUN.
    - StartStop -> PAUSE.
    - Target match -> DONE.
  - PAUSE: StartStop -> RUN; prescaler resumes from its held value; Lap ignored.
  - DONE: StartStop and Lap ignored.
  - Any state: Clear -> IDLE; CntnReset=0 for exactly one cycle; prescaler=0; lap register=000; Done=0.
- Target match: Target != 000 and {Co100,Co10,Co1} == Target, evaluated in RUN/LAP. Takes effect on the next edge; no CntEnable is issued in the cycle of the match or after it.
- Prescaler:
  - Increments in RUN/LAP; at PRESCALE-1 wraps to 0 and CntEnable=1 for that one cycle.
  - Holds in PAUSE; reset to 0 in IDLE/DONE.
  - First tick occurs PRESCALE cycles after entry to RUN from IDLE.
- A CntEnable issued in the same cycle as a StartStop or Clear event is still delivered; the counter may advance once.
- PRESCALE >= 2 guarantees the counter value updated by a tick is compared before the next tick.
- Target == 000: counter free-runs and wraps 999 -> 000; Done never asserts.
- Target not valid BCD (any nibble > 9): never matches; behaves as free-run.
- Display: in LAP, Disp = lap register; in all other states, Disp = {Co100,Co10,Co1} passed through combinationally.
- Running = state in {RUN, LAP}; Done = state==DONE; both registered decodes of state.
- Reset mid-operation overrides everything: state returns to IDLE and the counter is cleared via CntnReset=0.

Test Plan:
- Reset, release, StartStop pulse, PRESCALE=4, Target=000 -> CntEnable high every 4th cycle, first 4 cycles after the StartStop edge; counter reaches 005 after 20 cycles; Running=1.
- Run to 012, StartStop -> PAUSE, wait 50 cycles (count stays 012), StartStop -> next tick arrives after the remaining prescaler cycles; no lost or extra ticks.
- Run, Lap at count 034 -> Disp holds 034 while Co advances to 040; Lap again -> Disp follows live count; Running=1 throughout.
- Target=12'h025, run from 000 -> Done=1 with count 025; CntEnable stays 0 for 100 further cycles; StartStop ignored; Clear -> IDLE, CntnReset low one cycle, count 000, Done=0.
- Target=000, run past 999 -> count wraps to 000 and keeps counting; Done stays 0.
- Clear and StartStop rising in the same cycle while in RUN -> IDLE; no transition to PAUSE; nReset asserted mid-run -> IDLE, CntnReset=0, outputs at reset values.
